// File: rtl/overcooked_pkg.sv
// ---------------------------------------------------------------------------
// overcooked_pkg : sprite codes, tile count and interact FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package overcooked_pkg;

  localparam logic [2:0] SPR_NONE   = 3'd0;
  localparam logic [2:0] SPR_POT    = 3'd1;
  localparam logic [2:0] SPR_PLATE  = 3'd2;
  localparam logic [2:0] SPR_ONION1 = 3'd3;
  localparam logic [2:0] SPR_ONION2 = 3'd4;
  localparam logic [2:0] SPR_ONION3 = 3'd5;
  localparam logic [2:0] SPR_SOUP   = 3'd6;
  localparam logic [2:0] SPR_ORDER  = 3'd7;

  localparam int NUM_TILES = 120;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/interact_rules.sv
// ---------------------------------------------------------------------------
// interact_rules : maps held item, read sprite, tile and pot count to an action
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interact_rules
  import overcooked_pkg::*;
#(
  parameter logic [6:0] POT_TILE        = 7'd45,
  parameter logic [6:0] SERVE_TILE      = 7'd9,
  parameter int         ONIONS_PER_SOUP = 2
) (
  input  logic [2:0] heldItem,
  input  logic [2:0] rd,
  input  logic [6:0] tile,
  input  logic [1:0] onionCount,
  output logic       act,
  output logic       doWrite,
  output logic [2:0] wrData,
  output logic [2:0] newHeld,
  output logic       cntInc,
  output logic       cntClr,
  output logic       serve
);

  localparam logic [1:0] c_CNT_MAX   = 2'(ONIONS_PER_SOUP);
  localparam logic [6:0] c_NUM_TILES = 7'(NUM_TILES);

  logic w_onion_held;
  logic w_at_pot;

  assign w_onion_held = (heldItem >= SPR_ONION1) && (heldItem <= SPR_ONION3);
  assign w_at_pot     = w_onion_held && (tile == POT_TILE) && (rd == SPR_POT);

  // First matching rule wins; anything unmatched (incl. off-map tiles) is a no-op.
  always_comb begin
    act     = 1'b0;
    doWrite = 1'b0;
    wrData  = SPR_NONE;
    newHeld = heldItem;
    cntInc  = 1'b0;
    cntClr  = 1'b0;
    serve   = 1'b0;
    if (tile >= c_NUM_TILES) begin
      act = 1'b0;
    end else if ((heldItem == SPR_NONE) && (rd >= SPR_PLATE) && (rd <= SPR_SOUP)) begin
      act     = 1'b1;
      doWrite = 1'b1;
      wrData  = SPR_NONE;
      newHeld = rd;
    end else if (w_at_pot && (onionCount < c_CNT_MAX)) begin
      act     = 1'b1;
      cntInc  = 1'b1;
      newHeld = SPR_NONE;
    end else if (w_at_pot && (onionCount == c_CNT_MAX)) begin
      act     = 1'b1;
      doWrite = 1'b1;
      wrData  = SPR_SOUP;
      cntClr  = 1'b1;
      newHeld = SPR_NONE;
    end else if ((heldItem == SPR_PLATE) && (rd == SPR_SOUP)) begin
      act     = 1'b1;
      doWrite = 1'b1;
      wrData  = SPR_POT;
      newHeld = SPR_SOUP;
    end else if ((heldItem == SPR_SOUP) && (tile == SERVE_TILE)) begin
      act     = 1'b1;
      serve   = 1'b1;
      newHeld = SPR_NONE;
    end else if ((heldItem != SPR_NONE) && (rd == SPR_NONE) && (tile != SERVE_TILE)) begin
      act     = 1'b1;
      doWrite = 1'b1;
      wrData  = heldItem;
      newHeld = SPR_NONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/item_interact_ctrl.sv
// ---------------------------------------------------------------------------
// item_interact_ctrl : press-driven read/evaluate/write controller for the tile store
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module item_interact_ctrl
  import overcooked_pkg::*;
#(
  parameter logic [6:0] POT_TILE        = 7'd45,
  parameter logic [6:0] SERVE_TILE      = 7'd9,
  parameter int         ONIONS_PER_SOUP = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       interact,
  input  logic [6:0] facingTile,
  input  logic [2:0] spriteIndex,
  output logic [6:0] tileIndex,
  output logic       writeEnable,
  output logic [2:0] spriteIndexIn,
  output logic       respawnPlate,
  output logic [2:0] heldItem,
  output logic       soupServed,
  output logic       busy
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_interact_q;
  logic [1:0] r_onion_cnt;
  logic       w_press;

  logic       w_act;
  logic       w_do_write;
  logic [2:0] w_wr_data;
  logic [2:0] w_new_held;
  logic       w_cnt_inc;
  logic       w_cnt_clr;
  logic       w_serve;

  assign w_press = interact & ~r_interact_q;
  assign busy    = (r_state != S_IDLE);

  interact_rules #(
    .POT_TILE        (POT_TILE),
    .SERVE_TILE      (SERVE_TILE),
    .ONIONS_PER_SOUP (ONIONS_PER_SOUP)
  ) u_rules (
    .heldItem   (heldItem),
    .rd         (spriteIndex),
    .tile       (tileIndex),
    .onionCount (r_onion_cnt),
    .act        (w_act),
    .doWrite    (w_do_write),
    .wrData     (w_wr_data),
    .newHeld    (w_new_held),
    .cntInc     (w_cnt_inc),
    .cntClr     (w_cnt_clr),
    .serve      (w_serve)
  );

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_press) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = S_READ;
      S_READ:  w_state_nxt = w_act ? S_WRITE : S_IDLE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Action outputs are registered at the READ edge so they are visible exactly in WRITE.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_interact_q  <= 1'b1;
      tileIndex     <= 7'd0;
      spriteIndexIn <= SPR_NONE;
      writeEnable   <= 1'b0;
      respawnPlate  <= 1'b0;
      soupServed    <= 1'b0;
      heldItem      <= SPR_NONE;
      r_onion_cnt   <= 2'd0;
    end else begin
      r_interact_q <= interact;
      writeEnable  <= 1'b0;
      respawnPlate <= 1'b0;
      soupServed   <= 1'b0;
      if ((r_state == S_IDLE) && w_press) begin
        tileIndex <= facingTile;
      end
      if ((r_state == S_READ) && w_act) begin
        writeEnable   <= w_do_write;
        spriteIndexIn <= w_wr_data;
        respawnPlate  <= w_serve;
        soupServed    <= w_serve;
        heldItem      <= w_new_held;
        if (w_cnt_clr) begin
          r_onion_cnt <= 2'd0;
        end else if (w_cnt_inc) begin
          r_onion_cnt <= r_onion_cnt + 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_item_interact_ctrl.sv
// ---------------------------------------------------------------------------
// tb_item_interact_ctrl : directed bench with a registered tile-store model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_item_interact_ctrl;

  logic       clk;
  logic       Reset;
  logic       interact;
  logic [6:0] facingTile;
  logic [2:0] spriteIndex;
  logic [6:0] tileIndex;
  logic       writeEnable;
  logic [2:0] spriteIndexIn;
  logic       respawnPlate;
  logic [2:0] heldItem;
  logic       soupServed;
  logic       busy;

  logic [2:0] mem [128];
  int         n_checks;
  int         n_fail;
  int         we_cnt;

  item_interact_ctrl #(
    .POT_TILE        (7'd45),
    .SERVE_TILE      (7'd9),
    .ONIONS_PER_SOUP (2)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .interact      (interact),
    .facingTile    (facingTile),
    .spriteIndex   (spriteIndex),
    .tileIndex     (tileIndex),
    .writeEnable   (writeEnable),
    .spriteIndexIn (spriteIndexIn),
    .respawnPlate  (respawnPlate),
    .heldItem      (heldItem),
    .soupServed    (soupServed),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tracker: read data valid the cycle after the address, single-port write.
  always @(posedge clk) begin
    spriteIndex <= mem[tileIndex];
    if (writeEnable) mem[tileIndex] <= spriteIndexIn;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full interaction; expectations are sampled in the cycle three after the press.
  task automatic do_press(input string tag, input logic [6:0] tile, input logic we,
                          input logic [2:0] wdata, input logic srv, input logic [2:0] held);
    facingTile = tile;
    interact   = 1'b0;
    tick();
    interact = 1'b1;
    tick();
    check({tag, "_addr_busy"}, 8'(busy), 8'd1);
    check({tag, "_addr_we"}, 8'(writeEnable), 8'd0);
    tick();
    check({tag, "_read_we"}, 8'(writeEnable), 8'd0);
    tick();
    check({tag, "_we"}, 8'(writeEnable), 8'(we));
    if (we) begin
      check({tag, "_addr"}, 8'(tileIndex), 8'(tile));
      check({tag, "_data"}, 8'(spriteIndexIn), 8'(wdata));
    end
    check({tag, "_respawn"}, 8'(respawnPlate), 8'(srv));
    check({tag, "_served"}, 8'(soupServed), 8'(srv));
    check({tag, "_held"}, 8'(heldItem), 8'(held));
    tick();
    check({tag, "_idle"}, 8'(busy), 8'd0);
    check({tag, "_we_off"}, 8'(writeEnable), 8'd0);
    interact = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    Reset      = 1'b0;
    interact   = 1'b1;
    facingTile = 7'd0;
    for (int i = 0; i < 128; i++) mem[i] = 3'd0;

    repeat (2) tick();
    check("rst_held", 8'(heldItem), 8'd0);
    check("rst_tile", 8'(tileIndex), 8'd0);
    check("rst_wdata", 8'(spriteIndexIn), 8'd0);
    check("rst_we", 8'(writeEnable), 8'd0);
    check("rst_respawn", 8'(respawnPlate), 8'd0);
    check("rst_served", 8'(soupServed), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    Reset = 1'b1;
    repeat (3) begin
      tick();
      check("held_key_no_fire", 8'(busy), 8'd0);
    end

    // Pick up a plate, drop it, then fetch onions into the pot.
    mem[50] = 3'd2;
    do_press("pick_plate", 7'd50, 1'b1, 3'd0, 1'b0, 3'd2);
    check("mem50_cleared", 8'(mem[50]), 8'd0);
    do_press("drop_plate", 7'd60, 1'b1, 3'd2, 1'b0, 3'd0);
    check("mem60_plate", 8'(mem[60]), 8'd2);

    mem[45] = 3'd1;
    mem[61] = 3'd3;
    do_press("pick_on_a", 7'd61, 1'b1, 3'd0, 1'b0, 3'd3);
    do_press("pot_1", 7'd45, 1'b0, 3'd0, 1'b0, 3'd0);
    mem[61] = 3'd3;
    do_press("pick_on_b", 7'd61, 1'b1, 3'd0, 1'b0, 3'd3);
    do_press("pot_2", 7'd45, 1'b0, 3'd0, 1'b0, 3'd0);
    check("pot_still_pot", 8'(mem[45]), 8'd1);
    mem[61] = 3'd3;
    do_press("pick_on_c", 7'd61, 1'b1, 3'd0, 1'b0, 3'd3);
    do_press("pot_soup", 7'd45, 1'b1, 3'd6, 1'b0, 3'd0);
    check("pot_has_soup", 8'(mem[45]), 8'd6);

    // Plate collects soup, then serve at the window.
    mem[70] = 3'd2;
    do_press("pick_plate2", 7'd70, 1'b1, 3'd0, 1'b0, 3'd2);
    do_press("collect_soup", 7'd45, 1'b1, 3'd1, 1'b0, 3'd6);
    check("pot_restored", 8'(mem[45]), 8'd1);
    mem[9] = 3'd7;
    do_press("serve", 7'd9, 1'b0, 3'd0, 1'b1, 3'd0);

    // Count was cleared by the soup: one onion must not cook.
    mem[61] = 3'd3;
    do_press("pick_on_d", 7'd61, 1'b1, 3'd0, 1'b0, 3'd3);
    do_press("pot_after_clr", 7'd45, 1'b0, 3'd0, 1'b0, 3'd0);
    check("pot_no_soup", 8'(mem[45]), 8'd1);

    // Place onto empty tile, refuse onto occupied tile, off-map tile is a no-op.
    mem[62] = 3'd4;
    do_press("pick_on2", 7'd62, 1'b1, 3'd0, 1'b0, 3'd4);
    do_press("drop_on2", 7'd30, 1'b1, 3'd4, 1'b0, 3'd0);
    check("mem30_onion2", 8'(mem[30]), 8'd4);
    mem[62] = 3'd4;
    do_press("pick_on2_b", 7'd62, 1'b1, 3'd0, 1'b0, 3'd4);
    mem[30] = 3'd2;
    do_press("blocked", 7'd30, 1'b0, 3'd0, 1'b0, 3'd4);
    do_press("off_map", 7'd125, 1'b0, 3'd0, 1'b0, 3'd4);

    // Reset while in READ aborts the drop and empties the hands.
    mem[31]    = 3'd0;
    facingTile = 7'd31;
    interact   = 1'b0;
    tick();
    interact = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("abort_we", 8'(writeEnable), 8'd0);
    check("abort_held", 8'(heldItem), 8'd0);
    check("abort_busy", 8'(busy), 8'd0);
    Reset    = 1'b1;
    interact = 1'b0;
    repeat (3) tick();
    check("abort_mem31", 8'(mem[31]), 8'd0);

    // A second press while busy must not start another transaction.
    mem[63] = 3'd5;
    do_press("pick_on3", 7'd63, 1'b1, 3'd0, 1'b0, 3'd5);
    mem[63]    = 3'd0;
    mem[31]    = 3'd0;
    facingTile = 7'd31;
    interact   = 1'b0;
    tick();
    interact = 1'b1;
    tick();
    interact = 1'b0;
    tick();
    interact = 1'b1;
    we_cnt   = 0;
    repeat (6) begin
      tick();
      if (writeEnable) we_cnt++;
    end
    check("single_write", 8'(we_cnt), 8'd1);
    check("dbl_held", 8'(heldItem), 8'd0);
    check("mem31_onion3", 8'(mem[31]), 8'd5);
    interact = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/item_interact_ctrl.md
Name: item_interact_ctrl

Overview:
Writer side of the sprite tile store. On each player interact press it reads the sprite on the tile the player faces and applies the pick-up / drop / cook / serve rules. It then issues the resulting single-tile write (tileIndex, spriteIndexIn, writeEnable) and plate-respawn request to the tracker. It also owns the held-item register and the pot onion count.

Parameters:
POT_TILE, 7'd45, tile index of the pot.
SERVE_TILE, 7'd9, tile index of the serving window.
ONIONS_PER_SOUP, 2, onion-count value at which a third onion completes a soup (counter width 2).

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
interact  in  1  level from keyboard; rising edge requests an action
facingTile  in  7  tile index the player faces (0..119)
spriteIndex  in  3  tracker read data; valid the cycle after tileIndex is presented
tileIndex  out  7  tile address to tracker
writeEnable  out  1  one-cycle tile write strobe
spriteIndexIn  out  3  sprite code to write
respawnPlate  out  1  one-cycle plate respawn request
heldItem  out  3  sprite code carried by player (0 = empty)
soupServed  out  1  one-cycle pulse on successful serve
busy  out  1  high while not IDLE

Behaviour:
- Reset (Reset==0 at posedge) forces the following, regardless of state:
  - state=IDLE; heldItem=0; onionCount=0; tileIndex=0; spriteIndexIn=0.
  - writeEnable, respawnPlate, soupServed and busy all 0.
  - The interact edge-detect register is set to 1, so a key already held at release of reset does not fire.
- Press detect: press = interact & ~interact_q. Presses are ignored unless state==IDLE; they are neither queued nor counted.
- FSM states and transitions:
  - IDLE: on press, latch tileIndex<=facingTile and go to ADDR.
  - ADDR: one cycle; the tracker captures the address at the closing edge. Go to READ.
  - READ: sample spriteIndex into rd and evaluate the rules below. The actions (write, held update, pulses) occur in the WRITE cycle. Go to WRITE if an action exists, else to IDLE.
  - WRITE: one cycle. Assert the action's outputs, then go to IDLE.
- tileIndex is held stable from ADDR through WRITE. Total latency from press to write strobe is 3 cycles.
- Rules, priority top to bottom (h = heldItem, rd = sampled sprite):
  1. h==0, rd in {2,3,4,5,6} (plate, onions, soup): write 0 to the tile; heldItem<=rd. Pot (1) and 7 are not pickable.
  2. h in {3,4,5}, tile==POT_TILE, rd==1, onionCount<ONIONS_PER_SOUP: no tile write; onionCount+1; heldItem<=0.
  3. h in {3,4,5}, tile==POT_TILE, rd==1, onionCount==ONIONS_PER_SOUP: write 6 to the pot tile; onionCount<=0; heldItem<=0.
  4. h==2, rd==6: write 1 (pot restored) to the tile; heldItem<=6.
  5. h==6, tile==SERVE_TILE: no tile write; heldItem<=0; respawnPlate=1 and soupServed=1 for the WRITE cycle.
  6. h!=0, rd==0, tile!=SERVE_TILE: write h to the tile; heldItem<=0.
  7. Otherwise: no action; return to IDLE from READ, with nothing asserted.
- writeEnable and respawnPlate are never high in the same cycle; the tracker gives respawn priority.
- The counter never wraps past ONIONS_PER_SOUP. Rule 3 clears it.
- Reset mid-operation aborts the FSM with no write issued.
- Out-of-range facingTile (120..127) is treated as rule 7, with no write.

Decomposition:
- Shared package overcooked_pkg holds:
  - sprite code constants SPR_NONE=0, SPR_POT=1, SPR_PLATE=2, SPR_ONION1..3=3..5, SPR_SOUP=6, SPR_ORDER=7;
  - NUM_TILES=120;
  - the state enum typedef.
- One combinational sub-module, interact_rules, maps (heldItem, rd, tile, onionCount) to action fields: doWrite, wrData, newHeld, cntInc, cntClr, serve.

Test Plan:
- Reset low 2 cycles with interact=1, then release → all outputs 0, heldItem=0, no action until interact falls and rises again.
- heldItem=0, facingTile=50, tracker returns 2 → writeEnable exactly 3 cycles after press, tileIndex=50, spriteIndexIn=0; then heldItem=2.
- Carry onion 3 to POT_TILE (rd=1) three times → first two presses give no write and count 1,2; third writes 6 to tile 45 and clears the count.
- heldItem=2 at the pot with rd=6 → write 1, heldItem=6. Then press at SERVE_TILE → soupServed and respawnPlate high 1 cycle, writeEnable 0, heldItem=0.
- heldItem=4, facingTile=30 with rd=0 → write 4 to tile 30. Repeat with rd=2 → no write, heldItem unchanged at 4.
- Second press during ADDR/READ is ignored (single write seen). Reset asserted in READ → no writeEnable, and heldItem=0 next cycle.
